// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR multiply-accumulate datapath.
//   - default widths, output shift and tap count
//   - block FSM state encoding
//   - round_shift_sat(): golden round/shift/saturate at the default widths
// Optional build macro: FIR_MAC_CONVERGENT_EN selects round-half-to-even.
package fir_pkg;

    localparam int FIR_DATA_W = 16;
    localparam int FIR_COEF_W = 16;
    localparam int FIR_ACC_W  = 40;
    localparam int FIR_OUT_W  = 16;
    localparam int FIR_SHIFT  = 21;
    localparam int FIR_NTAPS  = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } fir_state_e;

    typedef struct packed {
        logic                 sat;
        logic [FIR_OUT_W-1:0] y;
    } fir_rs_t;

    localparam logic signed [FIR_ACC_W:0] FIR_ONE  = (FIR_ACC_W+1)'(1);
    localparam logic signed [FIR_ACC_W:0] FIR_HALF = FIR_ONE <<< (FIR_SHIFT-1);
    localparam logic signed [FIR_ACC_W:0] FIR_SMAX = (FIR_ONE <<< (FIR_OUT_W-1)) - FIR_ONE;
    localparam logic signed [FIR_ACC_W:0] FIR_SMIN = -(FIR_ONE <<< (FIR_OUT_W-1));

    // One guard bit above the accumulator keeps the +/-H step from wrapping.
    function automatic fir_rs_t round_shift_sat(input logic signed [FIR_ACC_W-1:0] acc);
        logic signed [FIR_ACC_W:0] x;
        logic signed [FIR_ACC_W:0] r;
        logic signed [FIR_ACC_W:0] s;
        fir_rs_t                   res;
        x = (FIR_ACC_W+1)'(acc);
`ifdef FIR_MAC_CONVERGENT_EN
        r = x + FIR_HALF - FIR_ONE + $signed({{FIR_ACC_W{1'b0}}, acc[FIR_SHIFT]});
`else
        r = acc[FIR_ACC_W-1] ? (x - FIR_HALF) : (x + FIR_HALF);
`endif
        s = r >>> FIR_SHIFT;
        if (s > FIR_SMAX) begin
            res.sat = 1'b1;
            res.y   = {1'b0, {(FIR_OUT_W-1){1'b1}}};
        end else if (s < FIR_SMIN) begin
            res.sat = 1'b1;
            res.y   = {1'b1, {(FIR_OUT_W-1){1'b0}}};
        end else begin
            res.sat = 1'b0;
            res.y   = s[FIR_OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: combinational round, arithmetic right shift and saturate
// of the accumulator down to the output width.
// Ports:
//   acc_in  in   ACC_W  signed accumulator value
//   y_out   out  OUT_W  rounded/shifted/clamped result
//   y_sat   out  1      result was clamped
// Optional build macro: FIR_MAC_CONVERGENT_EN selects round-half-to-even;
// otherwise halves round by adding (acc>=0) or subtracting H before the shift.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W = FIR_ACC_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int SHIFT = FIR_SHIFT
) (
    input  logic signed [ACC_W-1:0] acc_in,
    output logic        [OUT_W-1:0] y_out,
    output logic                    y_sat
);

    localparam logic signed [ACC_W:0] ONE  = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] HALF = ONE <<< (SHIFT-1);
    localparam logic signed [ACC_W:0] SMAX = (ONE <<< (OUT_W-1)) - ONE;
    localparam logic signed [ACC_W:0] SMIN = -(ONE <<< (OUT_W-1));

    logic signed [ACC_W:0] acc_x;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shf;

    always_comb begin
        acc_x = (ACC_W+1)'(acc_in);
`ifdef FIR_MAC_CONVERGENT_EN
        // H-1 rounds halves down; adding the LSB that survives the shift
        // bumps odd quotients up, landing every tie on the even value.
        rnd = acc_x + HALF - ONE + $signed({{ACC_W{1'b0}}, acc_in[SHIFT]});
`else
        rnd = acc_in[ACC_W-1] ? (acc_x - HALF) : (acc_x + HALF);
`endif
        shf = rnd >>> SHIFT;
        y_sat = 1'b0;
        y_out = shf[OUT_W-1:0];
        if (shf > SMAX) begin
            y_sat = 1'b1;
            y_out = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shf < SMIN) begin
            y_sat = 1'b1;
            y_out = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fir_mac_pipe.sv
// fir_mac_pipe: pipelined multiply-accumulate engine for the FIR datapath.
// Accumulates NTAPS a*b products per block, then rounds/shifts/saturates the
// sum to OUT_W and holds it until the output FIFO takes it.
// Ports:
//   clk, rstn              clock, synchronous active-low reset
//   start                  clear and begin a new block (aborts any block)
//   in_valid/in_ready      product input handshake, a_in/b_in operands
//   out_valid/out_ready    result handshake, y_out/y_sat result
//   acc_out, acc_ovf       live accumulator, sticky signed-overflow flag
//   tap_cnt, busy          products accepted this block, FSM not idle
// Optional build macro: FIR_MAC_CONVERGENT_EN (round half to even).
//
// state | meaning
// IDLE  | no block in flight
// ACCUM | accepting products
// DRAIN | last product moving through the adder
// HOLD  | register result, then wait for out_ready
module fir_mac_pipe
    import fir_pkg::*;
#(
    parameter  int DATA_W = FIR_DATA_W,
    parameter  int COEF_W = FIR_COEF_W,
    parameter  int ACC_W  = FIR_ACC_W,
    parameter  int OUT_W  = FIR_OUT_W,
    parameter  int SHIFT  = FIR_SHIFT,
    parameter  int NTAPS  = FIR_NTAPS,
    localparam int CNT_W  = $clog2(NTAPS+1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [COEF_W-1:0] b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  y_out,
    output logic              y_sat,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_ovf,
    output logic [CNT_W-1:0]  tap_cnt,
    output logic              busy
);

    localparam int               PROD_W   = DATA_W + COEF_W;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NTAPS-1);

    fir_state_e               state_q, state_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     pv_q, pv_d;
    logic [CNT_W-1:0]         tap_cnt_q, tap_cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     acc_ovf_q, acc_ovf_d;
    logic                     out_valid_q, out_valid_d;
    logic [OUT_W-1:0]         y_q, y_d;
    logic                     y_sat_q, y_sat_d;

    logic                     accept;
    logic signed [PROD_W-1:0] a_ext, b_ext;
    logic signed [ACC_W-1:0]  prod_ext, acc_sum;
    logic                     add_ovf;
    logic [OUT_W-1:0]         rs_y;
    logic                     rs_sat;

    fir_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc_in (acc_q),
        .y_out  (rs_y),
        .y_sat  (rs_sat)
    );

    always_comb begin
        in_ready = (state_q == ST_ACCUM) && !start;
        busy     = (state_q != ST_IDLE);
        accept   = in_valid && in_ready;

        a_ext    = PROD_W'($signed(a_in));
        b_ext    = PROD_W'($signed(b_in));
        prod_ext = ACC_W'(prod_q);
        acc_sum  = acc_q + prod_ext;
        // Overflow: operands share a sign that the wrapped sum does not.
        add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

        state_d     = state_q;
        prod_d      = prod_q;
        pv_d        = 1'b0;
        tap_cnt_d   = tap_cnt_q;
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        y_sat_d     = y_sat_q;

        if (pv_q) begin
            acc_d = acc_sum;
            if (add_ovf) begin
                acc_ovf_d = 1'b1;
            end
        end

        if (accept) begin
            prod_d    = a_ext * b_ext;
            pv_d      = 1'b1;
            tap_cnt_d = tap_cnt_q + 1'b1;
        end

        case (state_q)
            ST_ACCUM: begin
                if (accept && (tap_cnt_q == LAST_TAP)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // First HOLD cycle sees the final acc and captures the result.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    y_d         = rs_y;
                    y_sat_d     = rs_sat;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
            end
        endcase

        if (start) begin
            acc_d       = '0;
            tap_cnt_d   = '0;
            pv_d        = 1'b0;
            acc_ovf_d   = 1'b0;
            out_valid_d = 1'b0;
            state_d     = ST_ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            prod_q      <= '0;
            pv_q        <= 1'b0;
            tap_cnt_q   <= '0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_sat_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prod_q      <= prod_d;
            pv_q        <= pv_d;
            tap_cnt_q   <= tap_cnt_d;
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            y_sat_q     <= y_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y_out     = y_q;
    assign y_sat     = y_sat_q;
    assign acc_out   = acc_q;
    assign acc_ovf   = acc_ovf_q;
    assign tap_cnt   = tap_cnt_q;

endmodule

// File: tb/tb_fir_mac_pipe.sv
// tb_fir_mac_pipe: scoreboard bench for fir_mac_pipe. Three engines share the
// clock: index 0 NTAPS=4, index 1 NTAPS=64, index 2 NTAPS=2. Stimulus pushes
// the expected block result; a monitor pops on every output handshake.
// Optional build macro: FIR_MAC_CONVERGENT_EN changes tie expectations.
module tb_fir_mac_pipe;

    typedef struct {
        logic [15:0] y;
        logic        sat;
        logic [39:0] acc;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_r    [3];
    logic        in_valid_r [3];
    logic        oready_r   [3];
    logic [15:0] a_r        [3];
    logic [15:0] b_r        [3];
    logic        in_ready_w [3];
    logic        oval_w     [3];
    logic        ysat_w     [3];
    logic        ovf_w      [3];
    logic        busy_w     [3];
    logic [15:0] y_w        [3];
    logic [39:0] acc_w      [3];
    logic [7:0]  tcnt_w     [3];

    exp_t exp_q [3][$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NTG = (g == 0) ? 4 : ((g == 1) ? 64 : 2);
        logic [$clog2(NTG+1)-1:0] tc;
        fir_mac_pipe #(
            .DATA_W (16), .COEF_W (16), .ACC_W (40),
            .OUT_W  (16), .SHIFT  (21), .NTAPS (NTG)
        ) u_dut (
            .clk       (clk),
            .rstn      (rstn),
            .start     (start_r[g]),
            .in_valid  (in_valid_r[g]),
            .in_ready  (in_ready_w[g]),
            .a_in      (a_r[g]),
            .b_in      (b_r[g]),
            .out_valid (oval_w[g]),
            .out_ready (oready_r[g]),
            .y_out     (y_w[g]),
            .y_sat     (ysat_w[g]),
            .acc_out   (acc_w[g]),
            .acc_ovf   (ovf_w[g]),
            .tap_cnt   (tc),
            .busy      (busy_w[g])
        );
        assign tcnt_w[g] = 8'(tc);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Independent reference of the output rule at the default widths.
    function automatic logic [16:0] model_rs(input longint acc);
        longint s;
`ifdef FIR_MAC_CONVERGENT_EN
        s = (acc + 64'sd1048575 + ((acc >>> 21) & 64'sd1)) >>> 21;
`else
        if (acc >= 0) s = (acc + 64'sd1048576) >>> 21;
        else          s = (acc - 64'sd1048576) >>> 21;
`endif
        if (s > 32767)  return {1'b1, 16'h7fff};
        if (s < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(s)};
    endfunction

    task automatic push(input int i, input logic [15:0] y, input logic sat,
                        input logic [39:0] acc, input logic ovf);
        exp_t e;
        e.y = y; e.sat = sat; e.acc = acc; e.ovf = ovf;
        exp_q[i].push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rstn && oval_w[i] && oready_r[i] && !start_r[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("unexpected_out%0d", i), oval_w[i], 0);
                    end else begin
                        e = exp_q[i].pop_front();
                        check($sformatf("y_out%0d", i),   y_w[i],    e.y);
                        check($sformatf("y_sat%0d", i),   ysat_w[i], e.sat);
                        check($sformatf("acc_out%0d", i), acc_w[i],  e.acc);
                        check($sformatf("acc_ovf%0d", i), ovf_w[i],  e.ovf);
                    end
                end
            end
        end
    endtask

    task automatic pulse_start(input int i);
        start_r[i] = 1'b1;
        tick();
        start_r[i] = 1'b0;
    endtask

    task automatic feed(input int i, input logic [15:0] a, input logic [15:0] b, input int gap);
        for (int t = 0; t < gap; t++) begin
            in_valid_r[i] = 1'b0;
            a_r[i] = 16'($urandom);
            b_r[i] = 16'($urandom);
            tick();
        end
        in_valid_r[i] = 1'b1;
        a_r[i] = a;
        b_r[i] = b;
        for (int t = 0; t < 20; t++) begin
            mid();
            if (in_ready_w[i]) begin
                tick();
                in_valid_r[i] = 1'b0;
                return;
            end
            tick();
        end
        check($sformatf("accept_wait%0d", i), in_ready_w[i], 1);
        in_valid_r[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input bit rnd);
        for (int t = 0; t < 40; t++) begin
            if (rnd) oready_r[i] = 1'($urandom_range(0, 1));
            mid();
            if (!busy_w[i]) begin
                oready_r[i] = 1'b1;
                return;
            end
            tick();
        end
        check($sformatf("idle_wait%0d", i), busy_w[i], 0);
        oready_r[i] = 1'b1;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint acc_m;
        logic [15:0] ra, rb;
        logic [16:0] rs;

        for (int i = 0; i < 3; i++) begin
            start_r[i] = 1'b0; in_valid_r[i] = 1'b0; oready_r[i] = 1'b0;
            a_r[i] = '0; b_r[i] = '0;
        end
        fork
            monitor();
        join_none

        // Reset with random inputs on every engine.
        rstn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 3; i++) begin
                start_r[i] = 1'($urandom); in_valid_r[i] = 1'($urandom);
                oready_r[i] = 1'($urandom);
                a_r[i] = 16'($urandom); b_r[i] = 16'($urandom);
            end
            tick();
            mid();
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rst_in_ready%0d", i), in_ready_w[i], 0);
                check($sformatf("rst_out_valid%0d", i), oval_w[i], 0);
                check($sformatf("rst_y%0d", i), {ysat_w[i], y_w[i]}, 0);
                check($sformatf("rst_acc%0d", i), {ovf_w[i], acc_w[i]}, 0);
                check($sformatf("rst_tap_cnt%0d", i), tcnt_w[i], 0);
                check($sformatf("rst_busy%0d", i), busy_w[i], 0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            start_r[i] = 1'b0; in_valid_r[i] = 1'b0; oready_r[i] = 1'b0;
            a_r[i] = '0; b_r[i] = '0;
        end
        tick();
        rstn = 1'b1;
        tick();

        // NTAPS=4, 0.5*0.5 four times: latency then backpressure.
        push(0, 16'd512, 1'b0, 40'h00_4000_0000, 1'b0);
        pulse_start(0);
        for (int t = 0; t < 4; t++) feed(0, 16'd16384, 16'd16384, 0);
        mid();
        check("lat_k_out_valid", oval_w[0], 0);
        check("lat_k_tap_cnt", tcnt_w[0], 4);
        tick(); mid();
        check("lat_k1_out_valid", oval_w[0], 0);
        check("lat_k1_acc", acc_w[0], 40'h00_4000_0000);
        tick(); mid();
        check("lat_k2_out_valid", oval_w[0], 1);
        for (int t = 0; t < 5; t++) begin
            tick(); mid();
            check("bp_y_stable", y_w[0], 16'd512);
            check("bp_out_valid", oval_w[0], 1);
            check("bp_in_ready", in_ready_w[0], 0);
        end
        tick();
        oready_r[0] = 1'b1;
        mid();
        tick(); mid();
        check("bp_after_out_valid", oval_w[0], 0);
        check("bp_after_busy", busy_w[0], 0);
        tick();

        // NTAPS=64, (-1)*(-1): saturates high without accumulator overflow.
        oready_r[1] = 1'b1;
        push(1, 16'h7fff, 1'b1, 40'h10_0000_0000, 1'b0);
        pulse_start(1);
        for (int t = 0; t < 64; t++) feed(1, 16'h8000, 16'h8000, 0);
        wait_idle(1, 1'b0);
        tick();

        // Abort after 10 accepts; only the restarted block may come out.
        pulse_start(1);
        for (int t = 0; t < 10; t++) feed(1, 16'd1000, 16'd1000, 0);
        start_r[1] = 1'b1; in_valid_r[1] = 1'b1; a_r[1] = 16'd5; b_r[1] = 16'd5;
        mid();
        check("abort_in_ready", in_ready_w[1], 0);
        tick();
        start_r[1] = 1'b0; in_valid_r[1] = 1'b0;
        mid();
        check("abort_acc", acc_w[1], 0);
        check("abort_tap_cnt", tcnt_w[1], 0);
        tick();
        push(1, 16'd4096, 1'b0, 40'h02_0000_0000, 1'b0);
        for (int t = 0; t < 64; t++) feed(1, 16'd16384, 16'd8192, t % 3);
        wait_idle(1, 1'b0);
        tick();

        // NTAPS=2 exact tie at 0.5 LSB.
        oready_r[2] = 1'b1;
`ifdef FIR_MAC_CONVERGENT_EN
        push(2, 16'd0, 1'b0, 40'h00_0010_0000, 1'b0);
`else
        push(2, 16'd1, 1'b0, 40'h00_0010_0000, 1'b0);
`endif
        pulse_start(2);
        feed(2, 16'd1024, 16'd1024, 0);
        feed(2, 16'd0, 16'd0, 0);
        wait_idle(2, 1'b0);
        tick();

        // Random operands, random in_valid gaps and out_ready on NTAPS=4.
        for (int blk = 0; blk < 6; blk++) begin
            pulse_start(0);
            acc_m = 0;
            for (int t = 0; t < 4; t++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                acc_m += longint'($signed(ra)) * longint'($signed(rb));
                if (t == 3) begin
                    rs = model_rs(acc_m);
                    push(0, rs[15:0], rs[16], acc_m[39:0], 1'b0);
                end
                feed(0, ra, rb, $urandom_range(0, 2));
            end
            wait_idle(0, 1'b1);
            tick();
        end

        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("leftover_exp%0d", i), exp_q[i].size(), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
